alu_share_arb: RTL and testbench
================================

Name: alu_share_arb

Overview:
- Shares one 32-bit combinational ALU (instance `alu`) between NREQ requesters, e.g. the integer execute path and the branch/address-compare path.
- Each requester sees a valid/ready request channel and a valid/ready response channel.
- A round-robin arbiter issues at most one operation per cycle.
- Results are registered per requester, so accept-to-response latency is exactly 1 cycle.

Parameters:
- NREQ, 2, number of requesters; legal range 2..4.
- WIDTH, 32, operand/result width; fixed by the ALU, other values unsupported.

Ports:
- clk  in  1  rising-edge clock.
- resetn  in  1  reset, synchronous, active-low.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester request accepted this cycle.
- req_op  in  4*NREQ  ALU control code per requester; slice i = [4i+3:4i].
- req_unsigned  in  NREQ  SLT unsigned compare select.
- req_a  in  WIDTH*NREQ  operand A slices.
- req_b  in  WIDTH*NREQ  operand B slices.
- rsp_valid  out  NREQ  response held for requester.
- rsp_ready  in  NREQ  requester consumes response.
- rsp_result  out  WIDTH*NREQ  registered ALU result.
- rsp_zero  out  NREQ  registered ALU zero flag (a == b).
- busy  out  1  any rsp_valid set or any req_valid high.

Behaviour:
- Op codes:
  - AND = 4'b0000, OR = 4'b0001, ADD = 4'b0010, SUB = 4'b0110.
  - SLT = 4'b0111, XOR = 4'b1000.
  - Any other code yields result 0; the zero flag is still computed from a^b.
- Eligibility: requester i is eligible when req_valid[i] && (!rsp_valid[i] || rsp_ready[i]). The response slot must be free or draining this cycle.
- Arbitration:
  - Round-robin over eligible requesters, starting at index ptr.
  - Exactly one grant per cycle, or none.
  - req_ready = one-hot grant and is combinational from the inputs.
  - Requesters must hold req_* stable while req_valid && !req_ready.
- Pointer update: on a grant to index g, ptr <= (g+1) mod NREQ. With no grant, ptr holds.
- Datapath: a mux selects the granted requester's op/a/b/unsigned into the single ALU instance.
- Latency: a grant in cycle N sets rsp_valid[g], rsp_result[g] and rsp_zero[g] at edge N+1.
- Response hold: rsp_* stay stable while rsp_valid && !rsp_ready.
- rsp_valid[i] clears on rsp_ready[i] unless requester i is granted in the same cycle; a re-grant keeps it set with new data.
- Back-to-back: one requester can issue every cycle if it asserts rsp_ready every cycle.
- Contention: with all requesters continuously eligible, grants rotate 0,1,..,NREQ-1,0. No requester waits more than NREQ-1 cycles once eligible.
- Reset (resetn low at a clock edge):
  - rsp_valid = 0, rsp_result = 0, rsp_zero = 0, ptr = 0.
  - req_ready is 0 during reset cycles regardless of inputs.
  - Any in-flight response is dropped; no partial results are delivered after reset.
- Simultaneous events:
  - Consume and new grant on the same requester in the same cycle: the new result replaces the old one, with no bubble.
  - Grant to i while j drains: independent.
- rsp_ready while !rsp_valid is ignored.
- Arithmetic follows the ALU:
  - 33-bit sign/zero-extended operands.
  - SUB/SLT use invert-plus-carry.
  - SLT result is {31'b0, sum[32]}.

Decomposition:
- Package `alu_pkg`:
  - localparams for the six op codes.
  - WIDTH constant.
  - A function decoding op code to a mnemonic, for bench printing.
- Sub-module `rr_arbiter` (parameter N):
  - Inputs: eligible vector, ptr.
  - Outputs: one-hot grant and grant index.
  - Purely combinational; reused by other shared resources.
- Top level instantiates `rr_arbiter`, the operand mux, `alu`, and per-requester response registers.

Test Plan:
- Single op: resetn=1; req0 ADD a=5, b=7 -> req_ready[0] same cycle; next cycle rsp_valid[0]=1, rsp_result=12, rsp_zero=0.
- Compare ops:
  - req1 SLT a=32'hFFFFFFFF, b=1, unsigned=0 -> result 1.
  - Same with unsigned=1 -> result 0.
  - SUB a=b=9 -> result 0, zero=1.
- Contention: both requesters valid continuously, rsp_ready=1 -> grants alternate 0,1,0,1 starting at req0 after reset; each response arrives 1 cycle after its grant.
- Backpressure: req0 response pending with rsp_ready[0]=0 and req0 valid again -> req0 not granted and req1 granted every cycle. rsp_result[0] holds until rsp_ready[0]=1; the same cycle re-grants req0 with no bubble.
- Reset mid-operation: grant req0 XOR a=32'hF0F0F0F0, b=32'h0F0F0F0F, assert resetn=0 on the next edge -> rsp_valid=0, result 0, ptr=0. After release, req1-only traffic is granted immediately.
- Undefined op 4'b0011 with a=b=3 -> result 0, zero=1.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: operand width, control codes, and a mnemonic helper.
// Latency: n/a (constants and a pure function only).
// Backpressure: n/a.
//   Contents: WIDTH, OP_* control codes, op_name() returning a 3-char ASCII tag.
package alu_pkg;

  localparam int WIDTH = 32;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_XOR = 4'b1000;

  // Three ASCII characters packed MSB-first, so it prints with %s.
  function automatic logic [23:0] op_name(input logic [3:0] op);
    case (op)
      OP_AND:  return "AND";
      OP_OR:   return " OR";
      OP_ADD:  return "ADD";
      OP_SUB:  return "SUB";
      OP_SLT:  return "SLT";
      OP_XOR:  return "XOR";
      default: return "???";
    endcase
  endfunction

endpackage

// File: rtl/alu.sv
// 32-bit combinational ALU: AND/OR/ADD/SUB/SLT/XOR, unknown codes give 0.
// Latency: 0 cycles (purely combinational).
// Backpressure: none; output follows inputs.
//   Ports: op_i (control code), uns_i (SLT unsigned), a_i, b_i -> result_o, zero_o (a == b).
module alu
  import alu_pkg::*;
(
  input  logic [3:0]       op_i,
  input  logic             uns_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o
);

  logic [WIDTH:0] a_x;
  logic [WIDTH:0] b_x;
  logic [WIDTH:0] b_n;
  logic [WIDTH:0] sum;
  logic           sub;

  always_comb begin
    // One extra bit keeps the sign of a-b exact for both signednesses,
    // so SLT is just the top bit of the 33-bit difference.
    a_x = {(uns_i ? 1'b0 : a_i[WIDTH-1]), a_i};
    b_x = {(uns_i ? 1'b0 : b_i[WIDTH-1]), b_i};
    sub = (op_i == OP_SUB) || (op_i == OP_SLT);
    b_n = sub ? ~b_x : b_x;
    sum = a_x + b_n + {{WIDTH{1'b0}}, sub};

    case (op_i)
      OP_AND:  result_o = a_i & b_i;
      OP_OR:   result_o = a_i | b_i;
      OP_ADD:  result_o = sum[WIDTH-1:0];
      OP_SUB:  result_o = sum[WIDTH-1:0];
      OP_SLT:  result_o = {{(WIDTH-1){1'b0}}, sum[WIDTH]};
      OP_XOR:  result_o = a_i ^ b_i;
      default: result_o = '0;
    endcase

    zero_o = ~|(a_i ^ b_i);
  end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: first eligible index at or after ptr wins.
// Latency: 0 cycles (purely combinational; caller owns the pointer register).
// Backpressure: none; grant is zero when nothing is eligible.
//   Ports: elig_i (eligible vector), ptr_i (start index) -> gnt_o (one-hot), gnt_idx_o, gnt_vld_o.
module rr_arbiter #(
  parameter  int N  = 2,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  elig_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] gnt_idx_o,
  output logic          gnt_vld_o
);

  int idx;

  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    gnt_vld_o = 1'b0;
    idx       = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr_i) + k) % N;
      if (!gnt_vld_o && elig_i[idx]) begin
        gnt_vld_o = 1'b1;
        gnt_idx_o = IW'(idx);
      end
    end
    if (gnt_vld_o) gnt_o[gnt_idx_o] = 1'b1;
  end

endmodule

// File: rtl/alu_share_arb.sv
// Shares one ALU among NREQ requesters via round-robin, one issue per cycle.
// Latency: grant in cycle N -> registered response visible after edge N+1.
// Backpressure: a requester is only granted when its response slot is free or draining.
//   Ports: clk, resetn (sync, active-low); req_valid/req_ready/req_op/req_unsigned/req_a/req_b
//   per-requester request slices; rsp_valid/rsp_ready/rsp_result/rsp_zero per-requester
//   response slices; busy = any pending response or request.
module alu_share_arb
  import alu_pkg::*;
#(
  parameter int NREQ = 2
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [4*NREQ-1:0]     req_op,
  input  logic [NREQ-1:0]       req_unsigned,
  input  logic [WIDTH*NREQ-1:0] req_a,
  input  logic [WIDTH*NREQ-1:0] req_b,
  output logic [NREQ-1:0]       rsp_valid,
  input  logic [NREQ-1:0]       rsp_ready,
  output logic [WIDTH*NREQ-1:0] rsp_result,
  output logic [NREQ-1:0]       rsp_zero,
  output logic                  busy
);

  localparam int IW = $clog2(NREQ);

  logic [NREQ-1:0]                  elig;
  logic [NREQ-1:0]                  gnt;
  logic [IW-1:0]                    gnt_idx;
  logic                             gnt_vld;
  logic [IW-1:0]                    ptr_q;
  logic [IW-1:0]                    ptr_d;

  logic [3:0]                       alu_op;
  logic                             alu_uns;
  logic [WIDTH-1:0]                 alu_a;
  logic [WIDTH-1:0]                 alu_b;
  logic [WIDTH-1:0]                 alu_res;
  logic                             alu_zero;

  logic [NREQ-1:0]                  rsp_valid_q;
  logic [NREQ-1:0][WIDTH-1:0]       rsp_result_q;
  logic [NREQ-1:0]                  rsp_zero_q;

  // A slot that is being consumed this cycle can take a new result at the
  // same edge, which is what gives back-to-back issue with no bubble.
  // Gating with resetn keeps req_ready low in reset cycles.
  always_comb begin
    elig = resetn ? (req_valid & (~rsp_valid_q | rsp_ready)) : '0;
  end

  rr_arbiter #(.N(NREQ)) u_arb (
    .elig_i    (elig),
    .ptr_i     (ptr_q),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx),
    .gnt_vld_o (gnt_vld)
  );

  // With no grant the mux points at requester 0; the ALU output is unused then.
  always_comb begin
    alu_op  = req_op[4*int'(gnt_idx) +: 4];
    alu_uns = req_unsigned[gnt_idx];
    alu_a   = req_a[WIDTH*int'(gnt_idx) +: WIDTH];
    alu_b   = req_b[WIDTH*int'(gnt_idx) +: WIDTH];
  end

  alu alu (
    .op_i     (alu_op),
    .uns_i    (alu_uns),
    .a_i      (alu_a),
    .b_i      (alu_b),
    .result_o (alu_res),
    .zero_o   (alu_zero)
  );

  always_comb begin
    ptr_d = ptr_q;
    if (gnt_vld) begin
      ptr_d = (int'(gnt_idx) == NREQ - 1) ? '0 : gnt_idx + IW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      ptr_q        <= '0;
      rsp_valid_q  <= '0;
      rsp_result_q <= '0;
      rsp_zero_q   <= '0;
    end else begin
      ptr_q <= ptr_d;
      for (int i = 0; i < NREQ; i++) begin
        if (gnt[i]) begin
          rsp_valid_q[i]  <= 1'b1;
          rsp_result_q[i] <= alu_res;
          rsp_zero_q[i]   <= alu_zero;
        end else if (rsp_ready[i]) begin
          // Data is left as-is; only the valid flag drops.
          rsp_valid_q[i] <= 1'b0;
        end
      end
    end
  end

  assign req_ready  = gnt;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = rsp_result_q;
  assign rsp_zero   = rsp_zero_q;
  assign busy       = (|rsp_valid_q) || (|req_valid);

endmodule

// File: tb/tb_alu_share_arb.sv
module tb_alu_share_arb;
  import alu_pkg::*;

  localparam int N = 2;
  localparam int W = 32;

  logic             clk = 1'b0;
  logic             resetn;
  logic [N-1:0]     req_valid;
  logic [N-1:0]     req_ready;
  logic [4*N-1:0]   req_op;
  logic [N-1:0]     req_unsigned;
  logic [W*N-1:0]   req_a;
  logic [W*N-1:0]   req_b;
  logic [N-1:0]     rsp_valid;
  logic [N-1:0]     rsp_ready;
  logic [W*N-1:0]   rsp_result;
  logic [N-1:0]     rsp_zero;
  logic             busy;

  alu_share_arb #(.NREQ(N)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_op       (req_op),
    .req_unsigned (req_unsigned),
    .req_a        (req_a),
    .req_b        (req_b),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_result   (rsp_result),
    .rsp_zero     (rsp_zero),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  // Behavioural model: one response slot per requester and a rotating start index.
  int          m_ptr;
  bit          m_vld  [N];
  logic [31:0] m_res  [N];
  bit          m_zero [N];
  bit          hold   [N];
  int          gi;
  int          last_gnt;
  int          total = 0;
  int          bad   = 0;

  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic u,
                                          input logic [31:0] a, input logic [31:0] b);
    case (op)
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_SLT:  return u ? {31'b0, (a < b)} : {31'b0, ($signed(a) < $signed(b))};
      OP_XOR:  return a ^ b;
      default: return 32'h0;
    endcase
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_ptr = 0;
    for (int i = 0; i < N; i++) begin
      m_vld[i]  = 1'b0;
      m_res[i]  = 32'h0;
      m_zero[i] = 1'b0;
    end
  endtask

  // One clock: compare at the falling edge, advance the model at the rising edge.
  task automatic step();
    logic [N-1:0] eg;
    logic [N-1:0] mv;
    logic [3:0]   op;
    logic [31:0]  a;
    logic [31:0]  b;
    @(negedge clk);
    gi = -1;
    if (resetn) begin
      for (int k = 0; k < N; k++) begin
        int idx;
        idx = (m_ptr + k) % N;
        if (gi < 0 && req_valid[idx] && (!m_vld[idx] || rsp_ready[idx])) gi = idx;
      end
    end
    eg = '0;
    if (gi >= 0) eg[gi] = 1'b1;
    for (int i = 0; i < N; i++) mv[i] = m_vld[i];
    chk("req_ready", 64'(req_ready), 64'(eg));
    chk("rsp_valid", 64'(rsp_valid), 64'(mv));
    chk("busy", 64'(busy), 64'((|req_valid) || (|mv)));
    for (int i = 0; i < N; i++) begin
      if (m_vld[i]) begin
        chk("rsp_result", 64'(rsp_result[32*i +: 32]), 64'(m_res[i]));
        chk("rsp_zero", 64'(rsp_zero[i]), 64'(m_zero[i]));
      end
    end
    last_gnt = gi;
    for (int i = 0; i < N; i++) hold[i] = req_valid[i] && (gi != i);
    @(posedge clk);
    if (!resetn) begin
      model_reset();
    end else begin
      for (int i = 0; i < N; i++) begin
        if (i == gi) begin
          op = req_op[4*i +: 4];
          a  = req_a[32*i +: 32];
          b  = req_b[32*i +: 32];
          m_vld[i]  = 1'b1;
          m_res[i]  = ref_alu(op, req_unsigned[i], a, b);
          m_zero[i] = (a == b);
        end else if (rsp_ready[i]) begin
          m_vld[i] = 1'b0;
        end
      end
      if (gi >= 0) m_ptr = (gi + 1) % N;
    end
    #1;
  endtask

  task automatic set_req(input int i, input logic [3:0] op, input logic u,
                         input logic [31:0] a, input logic [31:0] b);
    req_valid[i]        = 1'b1;
    req_op[4*i +: 4]    = op;
    req_unsigned[i]     = u;
    req_a[32*i +: 32]   = a;
    req_b[32*i +: 32]   = b;
  endtask

  task automatic do_reset();
    resetn    = 1'b0;
    req_valid = '0;
    rsp_ready = '0;
    step();
    resetn = 1'b1;
  endtask

  function automatic logic [31:0] rnd_operand();
    case ($urandom_range(0, 4))
      0:       return 32'hFFFF_FFFF;
      1:       return 32'h8000_0000;
      2:       return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [3:0] ops [7];
    logic [31:0] a;
    logic [3:0]  o;
    ops = '{OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_XOR, 4'b0011};
    resetn       = 1'b0;
    req_valid    = '0;
    req_op       = '0;
    req_unsigned = '0;
    req_a        = '0;
    req_b        = '0;
    rsp_ready    = '0;
    model_reset();
    for (int i = 0; i < N; i++) hold[i] = 1'b0;
    // First edge initialises the DUT; nothing is defined before it.
    @(posedge clk);
    #1;

    // Reset state, with requests asserted to show req_ready stays low.
    req_valid = 2'b11;
    step();
    chk("reset_rsp_valid", 64'(rsp_valid), 64'h0);
    chk("reset_rsp_result", 64'(rsp_result), 64'h0);
    chk("reset_rsp_zero", 64'(rsp_zero), 64'h0);
    req_valid = '0;
    resetn = 1'b1;

    // Single ADD.
    set_req(0, OP_ADD, 1'b0, 32'd5, 32'd7);
    step();
    chk("single_gnt", 64'(last_gnt), 64'd0);
    req_valid = '0;
    chk("single_vld", 64'(rsp_valid[0]), 64'd1);
    chk("single_res", 64'(rsp_result[31:0]), 64'd12);
    chk("single_zero", 64'(rsp_zero[0]), 64'd0);

    // Compare ops on requester 1.
    rsp_ready = 2'b11;
    set_req(1, OP_SLT, 1'b0, 32'hFFFF_FFFF, 32'd1);
    step();
    chk("slt_s_res", 64'(rsp_result[63:32]), 64'd1);
    set_req(1, OP_SLT, 1'b1, 32'hFFFF_FFFF, 32'd1);
    step();
    chk("slt_u_res", 64'(rsp_result[63:32]), 64'd0);
    set_req(1, OP_SUB, 1'b0, 32'd9, 32'd9);
    step();
    chk("sub_res", 64'(rsp_result[63:32]), 64'd0);
    chk("sub_zero", 64'(rsp_zero[1]), 64'd1);
    req_valid = '0;
    step();

    // Contention after reset: grants alternate starting at 0.
    do_reset();
    rsp_ready = 2'b11;
    set_req(0, OP_ADD, 1'b0, 32'd100, 32'd1);
    set_req(1, OP_OR, 1'b0, 32'h00F0, 32'h000F);
    for (int k = 0; k < 6; k++) begin
      step();
      chk("rr_order", 64'(last_gnt), 64'(k % 2));
    end
    chk("rr_res0", 64'(rsp_result[31:0]), 64'd101);
    chk("rr_res1", 64'(rsp_result[63:32]), 64'h00FF);

    // Backpressure on requester 0 while requester 1 streams.
    do_reset();
    set_req(0, OP_XOR, 1'b0, 32'h1234_0000, 32'h0000_5678);
    step();
    chk("bp_first_gnt", 64'(last_gnt), 64'd0);
    set_req(0, OP_ADD, 1'b0, 32'd40, 32'd2);
    set_req(1, OP_AND, 1'b0, 32'hFF00_FF00, 32'h0FF0_0FF0);
    rsp_ready = 2'b10;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("bp_gnt1", 64'(last_gnt), 64'd1);
      chk("bp_hold0", 64'(rsp_result[31:0]), 64'h1234_5678);
    end
    rsp_ready = 2'b11;
    step();
    chk("bp_regrant0", 64'(last_gnt), 64'd0);
    chk("bp_new0", 64'(rsp_result[31:0]), 64'd42);
    chk("bp_vld0", 64'(rsp_valid[0]), 64'd1);
    req_valid = '0;
    step();

    // Reset mid-operation.
    set_req(0, OP_XOR, 1'b0, 32'hF0F0_F0F0, 32'h0F0F_0F0F);
    rsp_ready = 2'b00;
    step();
    chk("mid_gnt", 64'(last_gnt), 64'd0);
    chk("mid_res", 64'(rsp_result[31:0]), 64'hFFFF_FFFF);
    do_reset();
    chk("mid_rst_vld", 64'(rsp_valid), 64'h0);
    chk("mid_rst_res", 64'(rsp_result), 64'h0);
    set_req(1, OP_ADD, 1'b0, 32'd1, 32'd1);
    step();
    chk("mid_req1_gnt", 64'(last_gnt), 64'd1);
    req_valid = '0;
    rsp_ready = 2'b11;
    step();
    // Pointer back at 0 after reset: both valid -> 0 wins.
    do_reset();
    set_req(0, OP_OR, 1'b0, 32'd1, 32'd2);
    set_req(1, OP_OR, 1'b0, 32'd4, 32'd8);
    step();
    chk("ptr_after_rst", 64'(last_gnt), 64'd0);
    req_valid = 2'b10;
    rsp_ready = 2'b11;
    step();

    // Undefined op code.
    req_valid = '0;
    set_req(0, 4'b0011, 1'b0, 32'd3, 32'd3);
    step();
    chk("undef_res", 64'(rsp_result[31:0]), 64'd0);
    chk("undef_zero", 64'(rsp_zero[0]), 64'd1);
    req_valid = '0;
    step();

    // Randomized traffic against the model, with occasional resets.
    for (int c = 0; c < 600; c++) begin
      resetn = ($urandom_range(0, 59) != 0);
      for (int i = 0; i < N; i++) begin
        if (!hold[i]) begin
          req_valid[i] = ($urandom_range(0, 3) != 0);
          o = ops[$urandom_range(0, 6)];
          a = rnd_operand();
          set_req(i, o, 1'($urandom_range(0, 1)), a,
                  ($urandom_range(0, 4) == 0) ? a : rnd_operand());
          req_valid[i] = ($urandom_range(0, 3) != 0);
        end
        rsp_ready[i] = ($urandom_range(0, 2) != 0);
      end
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
